// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 selector family.
package mux_pkg;

   localparam int MODE_SEL  = 0;
   localparam int MODE_SCAN = 1;

   // Bits needed to index n items; never returns less than 1.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin channel pointer that advances after DWELL accepted loads.
module mux_scan_ptr
   import mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DWELL  = 1,
   localparam int SEL_W = clog2_min1(NUM_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   output logic [SEL_W-1:0] ptr
);

   localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
   localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(NUM_CH - 1);

   logic [7:0] dwell_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         dwell_cnt <= '0;
      end else if (adv) begin
         if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            ptr       <= (ptr == PTR_LAST) ? '0 : ptr + SEL_W'(1);
         end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/mux_nto1_reg.sv
// Parametrised N:1 selector with a registered, backpressurable output and
// either an external select or an internal round-robin scan.
module mux_nto1_reg
   import mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 1,
   parameter int MODE   = 0,
   parameter int DWELL  = 1,
   parameter int DROP_W = 8,
   localparam int SEL_W = clog2_min1(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] i,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     en,
   input  logic                     y_rdy,
   output logic [DATA_W-1:0]        y,
   output logic                     y_vld,
   output logic [SEL_W-1:0]         cur_sel,
   output logic                     sel_err,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

   // Handshake: y is transferred on any cycle with y_vld && y_rdy. A new
   // sample is loaded when en is high and the register is empty or being
   // drained that same cycle; otherwise en is refused and only counted.
   logic              load;
   logic              refuse;
   logic [SEL_W-1:0]  eff_sel;
   logic              sel_oor;
   logic [DATA_W-1:0] chan;

   assign load   = en && (!y_vld || y_rdy);
   assign refuse = en && y_vld && !y_rdy;

   generate
      if (MODE == MODE_SCAN) begin : g_scan
         logic unused_sel;
         assign unused_sel = ^sel;
         mux_scan_ptr #(
            .NUM_CH (NUM_CH),
            .DWELL  (DWELL)
         ) u_scan_ptr (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (load),
            .ptr   (eff_sel)
         );
         assign sel_oor = 1'b0;
      end else begin : g_sel
         assign eff_sel = sel;
         assign sel_oor = ({1'b0, sel} >= NUM_CH_V);
      end
   endgenerate

   // No channel matches an out-of-range index, so chan falls back to zero.
   always_comb begin
      chan = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (eff_sel == SEL_W'(k)) chan = i[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y        <= '0;
         y_vld    <= 1'b0;
         cur_sel  <= '0;
         sel_err  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         sel_err <= load && sel_oor;
         if (load) begin
            y       <= chan;
            cur_sel <= eff_sel;
            y_vld   <= 1'b1;
         end else if (y_rdy) begin
            y_vld <= 1'b0;
         end
         if (refuse && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: four configurations share one stimulus stream and
// are checked every cycle against a behavioural model plus directed literals.
module tb_mux_nto1_reg;

   // Instances: 0 = SEL/4ch, 1 = SEL/3ch, 2 = SCAN/3ch/dwell2, 3 = SCAN/4ch/dwell1/drop_w2
   localparam int NI = 4;
   localparam int CFG_NCH [NI] = '{4, 3, 3, 4};
   localparam int CFG_MODE[NI] = '{0, 0, 1, 1};
   localparam int CFG_DW  [NI] = '{1, 1, 2, 1};
   localparam int CFG_DMAX[NI] = '{255, 255, 255, 3};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] i;
   logic [1:0]  sel;
   logic        en;
   logic        y_rdy;

   logic [7:0] y_w   [NI];
   logic       vld_w [NI];
   logic [1:0] cur_w [NI];
   logic       err_w [NI];
   logic [7:0] drop_w[NI];
   logic [7:0] drop_a, drop_b, drop_c;
   logic [1:0] drop_d;

   assign drop_w[0] = drop_a;
   assign drop_w[1] = drop_b;
   assign drop_w[2] = drop_c;
   assign drop_w[3] = {6'b0, drop_d};

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   // Model state
   logic [7:0] m_y    [NI];
   bit         m_vld  [NI];
   int         m_cur  [NI];
   bit         m_err  [NI];
   int         m_drop [NI];
   int         m_loads[NI];

   mux_nto1_reg #(.NUM_CH(4), .DATA_W(8), .MODE(0), .DWELL(1), .DROP_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .en(en), .y_rdy(y_rdy),
      .y(y_w[0]), .y_vld(vld_w[0]), .cur_sel(cur_w[0]), .sel_err(err_w[0]), .drop_cnt(drop_a));
   mux_nto1_reg #(.NUM_CH(3), .DATA_W(8), .MODE(0), .DWELL(1), .DROP_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .i(i[23:0]), .sel(sel), .en(en), .y_rdy(y_rdy),
      .y(y_w[1]), .y_vld(vld_w[1]), .cur_sel(cur_w[1]), .sel_err(err_w[1]), .drop_cnt(drop_b));
   mux_nto1_reg #(.NUM_CH(3), .DATA_W(8), .MODE(1), .DWELL(2), .DROP_W(8)) u_c (
      .clk(clk), .rst_n(rst_n), .i(i[23:0]), .sel(sel), .en(en), .y_rdy(y_rdy),
      .y(y_w[2]), .y_vld(vld_w[2]), .cur_sel(cur_w[2]), .sel_err(err_w[2]), .drop_cnt(drop_c));
   mux_nto1_reg #(.NUM_CH(4), .DATA_W(8), .MODE(1), .DWELL(1), .DROP_W(2)) u_d (
      .clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .en(en), .y_rdy(y_rdy),
      .y(y_w[3]), .y_vld(vld_w[3]), .cur_sel(cur_w[3]), .sel_err(err_w[3]), .drop_cnt(drop_d));

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Behavioural model: scan position is derived from the number of loads
   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_y[k] = 8'h00; m_vld[k] = 0; m_cur[k] = 0;
         m_err[k] = 0; m_drop[k] = 0; m_loads[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < NI; k++) begin
         bit ld;
         bit rf;
         int eff;
         ld  = en && (!m_vld[k] || y_rdy);
         rf  = en && m_vld[k] && !y_rdy;
         eff = (CFG_MODE[k] == 1) ? (m_loads[k] / CFG_DW[k]) % CFG_NCH[k] : int'(sel);
         m_err[k] = 0;
         if (ld) begin
            m_y[k]   = (eff < CFG_NCH[k]) ? i[eff*8 +: 8] : 8'h00;
            m_cur[k] = eff;
            m_vld[k] = 1;
            m_err[k] = (CFG_MODE[k] == 0) && (eff >= CFG_NCH[k]);
            m_loads[k]++;
         end else if (m_vld[k] && y_rdy) begin
            m_vld[k] = 0;
         end
         if (rf && m_drop[k] < CFG_DMAX[k]) m_drop[k]++;
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   // Per-cycle compare against the model
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("m%0d_y", k),    y_w[k],    m_y[k]);
         chk($sformatf("m%0d_vld", k),  vld_w[k],  m_vld[k]);
         chk($sformatf("m%0d_cur", k),  cur_w[k],  m_cur[k]);
         chk($sformatf("m%0d_err", k),  err_w[k],  m_err[k]);
         chk($sformatf("m%0d_drop", k), drop_w[k], m_drop[k]);
      end
   end

   // Driver tasks
   task automatic drive(input logic e, input logic r, input logic [1:0] s);
      @(negedge clk);
      en = e; y_rdy = r; sel = s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic report();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      fails++;
      report();
      $fatal(1, "timeout");
   end

   initial begin
      en = 0; y_rdy = 0; sel = 0; i = 32'hD3C2B1A0;
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("rst_y", y_w[k], 0);
         chk("rst_vld", vld_w[k], 0);
         chk("rst_cur", cur_w[k], 0);
         chk("rst_err", err_w[k], 0);
         chk("rst_drop", drop_w[k], 0);
      end
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Selected channels, full throughput
      exp_q.push_back(8'hA0); exp_q.push_back(8'hB1);
      exp_q.push_back(8'hC2); exp_q.push_back(8'hD3);
      for (int s = 0; s < 4; s++) begin
         drive(1'b1, 1'b1, 2'(s));
         step();
         chk("p1_y", y_w[0], exp_q.pop_front());
         chk("p1_cur", cur_w[0], s);
         chk("p1_vld", vld_w[0], 1);
      end
      chk("p1_b_err_sel3", err_w[1], 1);
      drive(1'b0, 1'b1, 2'd0);
      step();
      chk("p1_drain_vld", vld_w[0], 0);
      chk("p1_hold_y", y_w[0], 8'hD3);

      // Backpressure: three refused strobes, data change ignored
      drive(1'b1, 1'b1, 2'd2);
      step();
      chk("p2_load_y", y_w[0], 8'hC2);
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, 1'b0, 2'd1);
         i = 32'h11223344;
         step();
      end
      chk("p2_y", y_w[0], 8'hC2);
      chk("p2_cur", cur_w[0], 2);
      chk("p2_drop", drop_w[0], 3);
      chk("p2_vld", vld_w[0], 1);
      drive(1'b0, 1'b1, 2'd0);
      i = 32'hD3C2B1A0;
      step();
      chk("p2_release_vld", vld_w[0], 0);
      chk("p2_release_y", y_w[0], 8'hC2);

      // Out-of-range select on the 3-channel instance
      drive(1'b1, 1'b1, 2'd3);
      step();
      chk("p3_y", y_w[1], 8'h00);
      chk("p3_cur", cur_w[1], 3);
      chk("p3_err", err_w[1], 1);
      chk("p3_vld", vld_w[1], 1);
      drive(1'b0, 1'b1, 2'd0);
      step();
      chk("p3_err_clear", err_w[1], 0);
      drive(1'b1, 1'b1, 2'd1);
      step();
      chk("p3_err_next", err_w[1], 0);
      chk("p3_y_next", y_w[1], 8'hB1);

      // Scan with dwell 2 and wrap
      do_reset();
      exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
      exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd2);
      exp_q.push_back(8'd0);
      for (int n = 0; n < 7; n++) begin
         drive(1'b1, 1'b1, 2'd0);
         step();
         chk("p4_scan_cur", cur_w[2], exp_q.pop_front());
      end

      // Scan under backpressure and drop saturation
      do_reset();
      drive(1'b1, 1'b1, 2'd0);
      step();
      for (int n = 0; n < 5; n++) begin
         drive(1'b1, 1'b0, 2'd0);
         step();
      end
      chk("p5_cur", cur_w[2], 0);
      chk("p5_y", y_w[2], 8'hA0);
      chk("p5_drop", drop_w[2], 5);
      chk("p5_d_cur", cur_w[3], 0);
      drive(1'b1, 1'b0, 2'd0);
      step();
      chk("p5_drop6", drop_w[2], 6);
      chk("p5_sat", drop_w[3], 3);
      drive(1'b1, 1'b1, 2'd0);
      step();
      chk("p5_next_cur", cur_w[2], 0);
      chk("p5_d_next_cur", cur_w[3], 1);

      // Asynchronous reset mid-stream with pointer at 2
      do_reset();
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, 1'b1, 2'd0);
         step();
      end
      drive(1'b1, 1'b0, 2'd0);
      step();
      chk("p6_pre_drop", drop_w[2], 1);
      chk("p6_pre_cur", cur_w[2], 1);
      @(negedge clk);
      en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("p6_async_y", y_w[2], 0);
      chk("p6_async_vld", vld_w[2], 0);
      chk("p6_async_cur", cur_w[2], 0);
      chk("p6_async_drop", drop_w[2], 0);
      chk("p6_async_d_cur", cur_w[3], 0);
      @(negedge clk) rst_n = 1'b1;
      drive(1'b1, 1'b1, 2'd0);
      step();
      chk("p6_first_cur", cur_w[2], 0);
      chk("p6_first_y", y_w[2], 8'hA0);
      chk("p6_d_first_cur", cur_w[3], 0);

      drive(1'b0, 1'b1, 2'd0);
      step();
      report();
      $finish;
   end

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised N:1 selector with a registered output. Successor to the combinational 4:1 channel select.
- Adds configurable channel count and data width, plus a compile-time mode: externally selected or internal round-robin scan.
- Output uses a valid/ready handshake so downstream logic can apply backpressure.
- Used wherever several sampled lanes share one downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..64.
- DATA_W, 1, width of each channel and of y.
- MODE, 0, 0 = MODE_SEL (channel taken from the sel port), 1 = MODE_SCAN (internal round-robin pointer).
- DWELL, 1, MODE_SCAN only: number of accepted loads per channel before the pointer advances; legal range 1..255.
- DROP_W, 8, width of the saturating drop counter.
- SEL_W, derived local constant = clog2(NUM_CH), minimum 1. It is not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i  in  NUM_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- sel  in  SEL_W  channel select; used in MODE_SEL only, ignored in MODE_SCAN.
- en  in  1  sample strobe; a request to load one channel into the output register.
- y_rdy  in  1  downstream ready.
- y  out  DATA_W  registered selected data.
- y_vld  out  1  y holds data that has not yet been consumed.
- cur_sel  out  SEL_W  index of the channel currently held in y.
- sel_err  out  1  one-cycle pulse: the last load used an out-of-range sel.
- drop_cnt  out  DROP_W  count of en strobes refused because of backpressure; saturating.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: y=0, y_vld=0, cur_sel=0, sel_err=0, drop_cnt=0, scan pointer=0, dwell count=0.
- Reset can assert mid-operation at any time and immediately forces all of the above values, regardless of any pending handshake.
- Load condition: load = en && (!y_vld || y_rdy).
- On load, on the next edge:
  - y is set to channel eff_sel.
  - cur_sel is set to eff_sel.
  - y_vld is set to 1.
- Latency: exactly 1 cycle from en to y_vld.
- Effective select:
  - MODE_SEL: eff_sel = sel.
  - MODE_SCAN: eff_sel = scan pointer.
- Out-of-range sel (MODE_SEL, sel >= NUM_CH; only possible when NUM_CH is not a power of 2):
  - Load still occurs, with y=0 and cur_sel=sel.
  - sel_err is high for exactly the cycle after the load; otherwise sel_err is 0.
- Consume: y_vld && y_rdy with no load on the same cycle clears y_vld next cycle; y holds its last value.
- Simultaneous consume and load (y_vld && y_rdy && en): the new data replaces the old back-to-back and y_vld stays 1. This gives full throughput of one transfer per cycle.
- Backpressure refusal: en && y_vld && !y_rdy.
  - The strobe is dropped; en is not sticky.
  - y, cur_sel and the scan pointer are unchanged.
  - drop_cnt increments and saturates at 2^DROP_W-1.
- Scan pointer (MODE_SCAN):
  - The dwell count increments on each load.
  - When the dwell count reaches DWELL-1 on a load, it returns to 0 and the pointer advances.
  - Pointer wrap: NUM_CH-1 -> 0.
  - The pointer never moves without a load.
  - With DWELL=1 the pointer advances on every load.
- In MODE_SEL the scan logic is absent and sel_err is functional. In MODE_SCAN sel_err is tied to 0.
- y_rdy while y_vld=0 has no effect.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package mux_pkg holds:
  - MODE_SEL=0, MODE_SCAN=1.
  - A clog2 function with a minimum return of 1.
- Sub-module mux_scan_ptr, instantiated only when MODE==MODE_SCAN:
  - Parameters NUM_CH and DWELL.
  - Ports clk, rst_n, adv (the load strobe), ptr (SEL_W bits).
  - Contains the pointer and dwell counter.
- The output register, handshake and drop counter live in the top module.

Test Plan:
- MODE_SEL, NUM_CH=4, DATA_W=8, i={8'hD3,8'hC2,8'hB1,8'hA0}, y_rdy=1, en pulses with sel=0,1,2,3 -> one cycle later y=A0,B1,C2,D3 with cur_sel matching and y_vld=1 continuously.
- Backpressure: load sel=2 then hold y_rdy=0 and pulse en 3 times with sel=1 -> y stays C2, cur_sel=2, drop_cnt=3; raise y_rdy with en=0 -> y_vld clears next cycle.
- NUM_CH=3, MODE_SEL, en with sel=3 -> y=0, cur_sel=3, sel_err high for exactly one cycle; next load with sel=1 -> sel_err=0.
- MODE_SCAN, NUM_CH=3, DWELL=2, en held high with y_rdy=1 for 7 cycles -> cur_sel sequence 0,0,1,1,2,2,0 (wrap).
- MODE_SCAN, y_rdy=0 after first load, en held for 5 cycles -> pointer frozen, cur_sel stays 0, drop_cnt=5; DROP_W=2 with 6 refusals -> drop_cnt saturates at 3.
- Assert rst_n low asynchronously mid-stream with y_vld=1 and pointer=2 -> y, y_vld, cur_sel, drop_cnt and pointer read 0 before the next clk edge; first load after release uses channel 0.
